id_ex_latch: RTL



---
 rtl/id_ex_latch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/id_ex_latch.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_latch
// Brief    : ID/EX pipeline register with stall hold, flush bubble and a
//            per-slot valid bit. Optional macro ID_EX_RS_FWD_EN adds the
//            registered rs field for the forwarding unit.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_latch #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [1:0]        ctlwb_in,
    input  logic [2:0]        ctlm_in,
    input  logic [3:0]        ctlex_in,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] readdat1_in,
    input  logic [DATA_W-1:0] readdat2_in,
    input  logic [DATA_W-1:0] signext_in,
    input  logic [REG_W-1:0]  instr_2016_in,
    input  logic [REG_W-1:0]  instr_1511_in,
`ifdef ID_EX_RS_FWD_EN
    input  logic [REG_W-1:0]  instr_2521_in,
    output logic [REG_W-1:0]  instrout_2521,
`endif
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic              regdst,
    output logic [1:0]        alu_op,
    output logic              alu_src,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [REG_W-1:0]  instrout_2016,
    output logic [REG_W-1:0]  instrout_1511,
    output logic              valid_out
);

    logic [1:0]        ctlwb_q,  ctlwb_d;
    logic [2:0]        ctlm_q,   ctlm_d;
    logic [3:0]        ctlex_q,  ctlex_d;
    logic [DATA_W-1:0] npc_q,    npc_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] sext_q,   sext_d;
    logic [REG_W-1:0]  rt_q,     rt_d;
    logic [REG_W-1:0]  rd_q,     rd_d;
    logic              valid_q,  valid_d;
`ifdef ID_EX_RS_FWD_EN
    logic [REG_W-1:0]  rs_q,     rs_d;
`endif

    always_comb begin
        ctlwb_d  = ctlwb_q;
        ctlm_d   = ctlm_q;
        ctlex_d  = ctlex_q;
        npc_d    = npc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        sext_d   = sext_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        valid_d  = valid_q;
`ifdef ID_EX_RS_FWD_EN
        rs_d     = rs_q;
`endif
        if (flush) begin
            // Bubble is bit-identical to the reset state
            ctlwb_d  = '0;
            ctlm_d   = '0;
            ctlex_d  = '0;
            npc_d    = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            sext_d   = '0;
            rt_d     = '0;
            rd_d     = '0;
            valid_d  = 1'b0;
`ifdef ID_EX_RS_FWD_EN
            rs_d     = '0;
`endif
        end else if (!stall) begin
            // An invalid slot must never carry write-enabling control downstream
            ctlwb_d  = valid_in ? ctlwb_in : 2'b00;
            ctlm_d   = valid_in ? ctlm_in  : 3'b000;
            ctlex_d  = ctlex_in;
            npc_d    = npc_in;
            rdata1_d = readdat1_in;
            rdata2_d = readdat2_in;
            sext_d   = signext_in;
            rt_d     = instr_2016_in;
            rd_d     = instr_1511_in;
            valid_d  = valid_in;
`ifdef ID_EX_RS_FWD_EN
            rs_d     = instr_2521_in;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctlwb_q  <= '0;
            ctlm_q   <= '0;
            ctlex_q  <= '0;
            npc_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            sext_q   <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
`ifdef ID_EX_RS_FWD_EN
            rs_q     <= '0;
`endif
        end else begin
            ctlwb_q  <= ctlwb_d;
            ctlm_q   <= ctlm_d;
            ctlex_q  <= ctlex_d;
            npc_q    <= npc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            sext_q   <= sext_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
`ifdef ID_EX_RS_FWD_EN
            rs_q     <= rs_d;
`endif
        end
    end

    assign wb_ctlout     = ctlwb_q;
    assign m_ctlout      = ctlm_q;
    assign regdst        = ctlex_q[3];
    assign alu_op        = ctlex_q[2:1];
    assign alu_src       = ctlex_q[0];
    assign funct         = sext_q[5:0];
    assign npcout        = npc_q;
    assign rdata1out     = rdata1_q;
    assign rdata2out     = rdata2_q;
    assign s_extendout   = sext_q;
    assign instrout_2016 = rt_q;
    assign instrout_1511 = rd_q;
    assign valid_out     = valid_q;
`ifdef ID_EX_RS_FWD_EN
    assign instrout_2521 = rs_q;
`endif

endmodule
`default_nettype wire
